// File: rtl/vga_char_sched_pkg.sv
// Shared constants and types for the VGA character scheduler.
//   NUM_CHARS  : characters held (3 rows x 12 columns), index 0 = row 1 col 1
//   IDX_W      : width of a character index
//   BLANK_CHAR : reset/clear fill value (ASCII space)
//   DISP_W     : width of the flattened display buffer, char i at [8i+7:8i]
// Optional feature macro: VGA_SCHED_CLEAR_EN adds the CLEAR state.
package vga_char_sched_pkg;

  localparam int unsigned TEXT_ROWS  = 3;
  localparam int unsigned TEXT_COLS  = 12;
  localparam int unsigned NUM_CHARS  = TEXT_ROWS * TEXT_COLS;
  localparam int unsigned IDX_W      = 6;
  localparam int unsigned DISP_W     = NUM_CHARS * 8;
  localparam logic [7:0]  BLANK_CHAR = 8'h20;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StServe  = 2'd1,
`ifdef VGA_SCHED_CLEAR_EN
    StCommit = 2'd2,
    StClear  = 2'd3
`else
    StCommit = 2'd2
`endif
  } sched_state_e;

  // True when idx addresses a real character cell.
  function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
    return (32'(idx) < NUM_CHARS);
  endfunction

endpackage

// File: rtl/vga_char_sched_if.sv
// Handshake bundle between the character scheduler and its requesters.
//   master : requesters/VGA side (drives requests and frame_tick)
//   slave  : scheduler side (drives acks, status and the display buffer)
// Signals: frame_tick, cpu_req/idx/char/ack, dbg_req/idx/char/ack, clr_req/ack,
//          bad_idx, busy, commit_done, disp_chars.
interface vga_char_sched_if;
  import vga_char_sched_pkg::*;

  logic              frame_tick;
  logic              cpu_req;
  logic [IDX_W-1:0]  cpu_idx;
  logic [7:0]        cpu_char;
  logic              cpu_ack;
  logic              dbg_req;
  logic [IDX_W-1:0]  dbg_idx;
  logic [7:0]        dbg_char;
  logic              dbg_ack;
  logic              clr_req;
  logic              clr_ack;
  logic              bad_idx;
  logic              busy;
  logic              commit_done;
  logic [DISP_W-1:0] disp_chars;

  modport master (
    output frame_tick, cpu_req, cpu_idx, cpu_char, dbg_req, dbg_idx, dbg_char, clr_req,
    input  cpu_ack, dbg_ack, clr_ack, bad_idx, busy, commit_done, disp_chars
  );

  modport slave (
    input  frame_tick, cpu_req, cpu_idx, cpu_char, dbg_req, dbg_idx, dbg_char, clr_req,
    output cpu_ack, dbg_ack, clr_ack, bad_idx, busy, commit_done, disp_chars
  );

endinterface

// File: rtl/vga_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   i_req    : request vector, bit 0 = CPU, bit 1 = debug
//   i_take   : the current grant is being consumed this cycle
//   o_grant  : one-hot grant (combinational)
// The priority pointer only moves on a tie, and then to the side that lost.
module vga_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_grant
);

  // 0: CPU wins a tie, 1: debug wins a tie
  logic r_ptr;

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_take && (i_req == 2'b11)) begin
      r_ptr <= ~r_ptr;
    end
  end

endmodule

// File: rtl/vga_char_sched.sv
// VGA text-buffer scheduler: CPU and debug writers share a shadow buffer through a round-robin
// arbiter; the shadow is copied into the display buffer only after a frame_tick, so a frame never
// shows a half-updated line.
//   clk, rst : clock, asynchronous active-high reset
//   io_bus   : vga_char_sched_if.slave (requests, acks, status, disp_chars)
// Optional feature macro: VGA_SCHED_CLEAR_EN enables clr_req (blank the shadow buffer);
// without it clr_req is ignored and clr_ack is tied low.
module vga_char_sched
  import vga_char_sched_pkg::*;
(
  input logic            clk,
  input logic            rst,
  vga_char_sched_if.slave io_bus
);

  sched_state_e      r_state;
  logic [IDX_W-1:0]  r_cnt;
  logic [7:0]        r_shadow [NUM_CHARS];
  logic [DISP_W-1:0] r_disp;
  logic              r_dirty;
  logic              r_commit_pend;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        r_char;
  logic              r_cpu_ack;
  logic              r_dbg_ack;
  logic              r_bad_idx;
  logic              r_commit_done;

  logic [1:0]        w_grant;
  logic              w_commit_start;
  logic              w_clr_start;
  logic              w_serve_start;
  logic [IDX_W-1:0]  w_sel_idx;
  logic [7:0]        w_sel_char;

  vga_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   ({io_bus.dbg_req, io_bus.cpu_req}),
    .i_take  (w_serve_start),
    .o_grant (w_grant)
  );

  assign w_commit_start = (r_state == StIdle) && r_commit_pend && r_dirty;

`ifdef VGA_SCHED_CLEAR_EN
  logic r_clr_ack;
  // r_clr_ack blocks a restart while the requester still holds clr_req in the ack cycle.
  assign w_clr_start = (r_state == StIdle) && !w_commit_start && io_bus.clr_req && !r_clr_ack;
  assign io_bus.clr_ack = r_clr_ack;
`else
  logic w_unused_clr;
  assign w_unused_clr   = io_bus.clr_req;
  assign w_clr_start    = 1'b0;
  assign io_bus.clr_ack = 1'b0;
`endif

  assign w_serve_start = (r_state == StIdle) && !w_commit_start && !w_clr_start &&
                         (w_grant != 2'b00);
  assign w_sel_idx     = w_grant[1] ? io_bus.dbg_idx  : io_bus.cpu_idx;
  assign w_sel_char    = w_grant[1] ? io_bus.dbg_char : io_bus.cpu_char;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_disp        <= {NUM_CHARS{BLANK_CHAR}};
      r_dirty       <= 1'b0;
      r_commit_pend <= 1'b0;
      r_idx         <= '0;
      r_char        <= BLANK_CHAR;
      r_cpu_ack     <= 1'b0;
      r_dbg_ack     <= 1'b0;
      r_bad_idx     <= 1'b0;
      r_commit_done <= 1'b0;
`ifdef VGA_SCHED_CLEAR_EN
      r_clr_ack     <= 1'b0;
`endif
      for (int i = 0; i < int'(NUM_CHARS); i++) begin
        r_shadow[i] <= BLANK_CHAR;
      end
    end else begin
      r_cpu_ack     <= 1'b0;
      r_dbg_ack     <= 1'b0;
      r_bad_idx     <= 1'b0;
      r_commit_done <= 1'b0;
`ifdef VGA_SCHED_CLEAR_EN
      r_clr_ack     <= 1'b0;
`endif
      // A tick during a commit is already covered by that commit.
      if (io_bus.frame_tick && (r_state != StCommit)) begin
        r_commit_pend <= 1'b1;
      end

      unique case (r_state)
        StIdle: begin
          if (w_commit_start) begin
            r_state <= StCommit;
            r_cnt   <= '0;
          end else begin
            // Pending frame with nothing new to show: drop it.
            if (r_commit_pend && !io_bus.frame_tick) begin
              r_commit_pend <= 1'b0;
            end
`ifdef VGA_SCHED_CLEAR_EN
            if (w_clr_start) begin
              r_state <= StClear;
              r_cnt   <= '0;
            end
`endif
            if (w_serve_start) begin
              r_state   <= StServe;
              r_idx     <= w_sel_idx;
              r_char    <= w_sel_char;
              r_cpu_ack <= w_grant[0];
              r_dbg_ack <= w_grant[1];
              r_bad_idx <= !idx_valid(w_sel_idx);
            end
          end
        end

        StServe: begin
          if (idx_valid(r_idx)) begin
            r_shadow[r_idx] <= r_char;
            r_dirty         <= 1'b1;
          end
          r_state <= StIdle;
        end

        StCommit: begin
          r_disp[{r_cnt, 3'b000} +: 8] <= r_shadow[r_cnt];
          if (r_cnt == LAST_IDX) begin
            r_dirty       <= 1'b0;
            r_commit_pend <= 1'b0;
            r_commit_done <= 1'b1;
            r_state       <= StIdle;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

`ifdef VGA_SCHED_CLEAR_EN
        StClear: begin
          r_shadow[r_cnt] <= BLANK_CHAR;
          if (r_cnt == LAST_IDX) begin
            r_dirty   <= 1'b1;
            r_clr_ack <= 1'b1;
            r_state   <= StIdle;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif

        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.cpu_ack     = r_cpu_ack;
  assign io_bus.dbg_ack     = r_dbg_ack;
  assign io_bus.bad_idx     = r_bad_idx;
  assign io_bus.commit_done = r_commit_done;
  assign io_bus.busy        = (r_state != StIdle);
  assign io_bus.disp_chars  = r_disp;

endmodule

// File: tb/tb_vga_char_sched.sv
// Directed self-checking bench for vga_char_sched. Inputs change and outputs are sampled on the
// falling clock edge; expected display contents come from a small shadow/display model.
module tb_vga_char_sched;
  import vga_char_sched_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_char_sched_if bus_if ();

  vga_char_sched u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]        m_shadow [NUM_CHARS];
  logic [DISP_W-1:0] m_disp;
  logic [DISP_W-1:0] all_blank;
  logic [DISP_W-1:0] all_a;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkv(input string tag, input logic [DISP_W-1:0] obs,
                        input logic [DISP_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < int'(NUM_CHARS); i++) m_shadow[i] = BLANK_CHAR;
    m_disp = all_blank;
  endtask

  task automatic m_write(input int idx, input logic [7:0] ch);
    if (idx >= 0 && idx < int'(NUM_CHARS)) m_shadow[idx] = ch;
  endtask

  task automatic m_commit();
    for (int i = 0; i < int'(NUM_CHARS); i++) m_disp[i*8 +: 8] = m_shadow[i];
  endtask

  task automatic frame_pulse();
    bus_if.frame_tick = 1'b1;
    tick();
    bus_if.frame_tick = 1'b0;
  endtask

  task automatic wait_commit(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (bus_if.commit_done !== 1'b1 && lat < 200);
  endtask

  task automatic cpu_write(input int idx, input logic [7:0] ch);
    int t;
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_idx  = IDX_W'(idx);
    bus_if.cpu_char = ch;
    t = 0;
    do begin
      tick();
      t++;
    end while (bus_if.cpu_ack !== 1'b1 && t < 100);
    check1("cpu_write_ack", bus_if.cpu_ack, 1'b1);
    bus_if.cpu_req = 1'b0;
    tick();
    m_write(idx, ch);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat;
    int   cd_t;
    int   ack_t;
    logic seen;
    logic cpu_first;

    all_blank = {NUM_CHARS{BLANK_CHAR}};
    all_a     = {NUM_CHARS{8'h41}};
    rst = 1'b1;
    bus_if.frame_tick = 1'b0;
    bus_if.cpu_req = 1'b0; bus_if.cpu_idx = '0; bus_if.cpu_char = '0;
    bus_if.dbg_req = 1'b0; bus_if.dbg_idx = '0; bus_if.dbg_char = '0;
    bus_if.clr_req = 1'b0;
    m_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    checkv("reset_disp", bus_if.disp_chars, all_blank);
    check1("reset_busy", bus_if.busy, 1'b0);
    check1("reset_cpu_ack", bus_if.cpu_ack, 1'b0);
    check1("reset_dbg_ack", bus_if.dbg_ack, 1'b0);
    check1("reset_clr_ack", bus_if.clr_ack, 1'b0);
    check1("reset_bad_idx", bus_if.bad_idx, 1'b0);
    check1("reset_commit_done", bus_if.commit_done, 1'b0);

    // Frame ticks with nothing dirty never start a commit
    seen = 1'b0;
    repeat (3) begin
      frame_pulse();
      repeat (4) begin
        seen |= bus_if.busy | bus_if.commit_done;
        tick();
      end
    end
    check1("idle_ticks_no_commit", seen, 1'b0);
    checkv("idle_ticks_disp", bus_if.disp_chars, all_blank);

    // Single CPU write, ack one cycle after the request
    bus_if.cpu_req = 1'b1; bus_if.cpu_idx = 6'd0; bus_if.cpu_char = 8'h48;
    tick();
    check1("h_cpu_ack", bus_if.cpu_ack, 1'b1);
    check1("h_dbg_ack", bus_if.dbg_ack, 1'b0);
    check1("h_bad_idx", bus_if.bad_idx, 1'b0);
    check1("h_busy", bus_if.busy, 1'b1);
    bus_if.cpu_req = 1'b0;
    tick();
    check1("h_ack_pulse", bus_if.cpu_ack, 1'b0);
    m_write(0, 8'h48);
    repeat (5) tick();
    checkv("h_disp_hold", bus_if.disp_chars, all_blank);
    frame_pulse();
    tick();
    check1("commit_busy", bus_if.busy, 1'b1);
    checkv("commit_disp_pre", bus_if.disp_chars, all_blank);
    wait_commit(lat);
    checkn("commit_latency", lat, 36);
    m_commit();
    checkv("commit_disp", bus_if.disp_chars, m_disp);
    checkn("commit_byte0", int'(bus_if.disp_chars[7:0]), 'h48);
    check1("commit_done_busy", bus_if.busy, 1'b0);
    tick();
    check1("commit_done_pulse", bus_if.commit_done, 1'b0);

    // Simultaneous requests: first grant alternates CPU, dbg, CPU, dbg
    for (int e = 0; e < 4; e++) begin
      cpu_first = ((e % 2) == 0);
      bus_if.cpu_req = 1'b1; bus_if.cpu_idx = IDX_W'(1 + e); bus_if.cpu_char = 8'(8'h61 + e);
      bus_if.dbg_req = 1'b1; bus_if.dbg_idx = IDX_W'(6 + e); bus_if.dbg_char = 8'(8'h41 + e);
      tick();
      check1("tie_first_cpu_ack", bus_if.cpu_ack, cpu_first);
      check1("tie_first_dbg_ack", bus_if.dbg_ack, !cpu_first);
      if (cpu_first) bus_if.cpu_req = 1'b0;
      else bus_if.dbg_req = 1'b0;
      tick();
      check1("tie_gap_no_ack", bus_if.cpu_ack | bus_if.dbg_ack, 1'b0);
      tick();
      check1("tie_second_cpu_ack", bus_if.cpu_ack, !cpu_first);
      check1("tie_second_dbg_ack", bus_if.dbg_ack, cpu_first);
      bus_if.cpu_req = 1'b0;
      bus_if.dbg_req = 1'b0;
      tick();
      m_write(1 + e, 8'(8'h61 + e));
      m_write(6 + e, 8'(8'h41 + e));
    end
    frame_pulse();
    wait_commit(lat);
    checkn("tie_commit_latency", lat, 37);
    m_commit();
    checkv("tie_commit_disp", bus_if.disp_chars, m_disp);

    // Out-of-range debug write: acked with bad_idx, nothing becomes dirty
    bus_if.dbg_req = 1'b1; bus_if.dbg_idx = 6'd40; bus_if.dbg_char = 8'h5a;
    tick();
    check1("bad_dbg_ack", bus_if.dbg_ack, 1'b1);
    check1("bad_idx_pulse", bus_if.bad_idx, 1'b1);
    check1("bad_cpu_ack", bus_if.cpu_ack, 1'b0);
    bus_if.dbg_req = 1'b0;
    tick();
    check1("bad_idx_clear", bus_if.bad_idx, 1'b0);
    frame_pulse();
    seen = 1'b0;
    repeat (45) begin
      seen |= bus_if.busy | bus_if.commit_done;
      tick();
    end
    check1("bad_no_commit", seen, 1'b0);
    checkv("bad_disp", bus_if.disp_chars, m_disp);

    // CPU request during COMMIT stalls until commit_done, acked the cycle after
    cpu_write(11, 8'h51);
    frame_pulse();
    tick();
    bus_if.cpu_req = 1'b1; bus_if.cpu_idx = 6'd12; bus_if.cpu_char = 8'h52;
    cd_t  = -1;
    ack_t = -1;
    for (int t = 1; t <= 100; t++) begin
      tick();
      if (bus_if.commit_done === 1'b1) cd_t = t;
      if (bus_if.cpu_ack === 1'b1) begin
        ack_t = t;
        break;
      end
    end
    checkn("stall_commit_done_t", cd_t, 36);
    checkn("stall_ack_t", ack_t, 37);
    m_commit();
    bus_if.cpu_req = 1'b0;
    tick();
    m_write(12, 8'h52);
    checkv("stall_disp", bus_if.disp_chars, m_disp);

`ifdef VGA_SCHED_CLEAR_EN
    // Fill with 'A', commit, clear the shadow, commit again
    for (int i = 0; i < int'(NUM_CHARS); i++) cpu_write(i, 8'h41);
    frame_pulse();
    wait_commit(lat);
    m_commit();
    checkv("fill_disp", bus_if.disp_chars, all_a);
    tick();
    bus_if.clr_req = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (bus_if.clr_ack !== 1'b1 && lat < 100);
    checkn("clr_latency", lat, 37);
    bus_if.clr_req = 1'b0;
    checkv("clr_disp_hold", bus_if.disp_chars, all_a);
    tick();
    check1("clr_ack_pulse", bus_if.clr_ack, 1'b0);
    check1("clr_idle", bus_if.busy, 1'b0);
    for (int i = 0; i < int'(NUM_CHARS); i++) m_shadow[i] = BLANK_CHAR;
    frame_pulse();
    wait_commit(lat);
    m_commit();
    checkv("clr_commit_disp", bus_if.disp_chars, all_blank);
`else
    // Without the clear feature clr_req is ignored
    bus_if.clr_req = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      seen |= bus_if.clr_ack | bus_if.busy;
      tick();
    end
    bus_if.clr_req = 1'b0;
    check1("clr_ignored", seen, 1'b0);
`endif

    // Reset asserted mid-COMMIT returns everything to blank at once
    cpu_write(0, 8'h58);
    frame_pulse();
    repeat (5) tick();
    check1("mid_commit_busy", bus_if.busy, 1'b1);
    checkn("mid_commit_byte0", int'(bus_if.disp_chars[7:0]), 'h58);
    rst = 1'b1;
    #1;
    checkv("rst_mid_commit_disp", bus_if.disp_chars, all_blank);
    check1("rst_mid_commit_busy", bus_if.busy, 1'b0);
    tick();
    rst = 1'b0;
    m_reset();
    tick();
    check1("post_rst_busy", bus_if.busy, 1'b0);
    checkv("post_rst_disp", bus_if.disp_chars, m_disp);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
